// File: rtl/serial_deserializer.sv
// Receive end of the single-wire serial link: frames start/data(LSB first)/[parity]/stop
// into WIDTH-bit words on a valid/ready port. Define SERIAL_DESER_PARITY_EN for even parity.
module serial_deserializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic              commit;
`ifdef SERIAL_DESER_PARITY_EN
  logic              par_q, par_d;
  logic              parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    // A pending word is consumed unless a commit below overrides it.
    dout_valid_d = dout_valid_q & ~dout_ready;
    overflow_d   = 1'b0;
    frame_err_d  = 1'b0;
    commit       = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (din) begin
          state_d = StData;
          cnt_d   = '0;
`ifdef SERIAL_DESER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      StData: begin
        shift_d[cnt_q] = din;
`ifdef SERIAL_DESER_PARITY_EN
        par_d = par_q ^ din;
`endif
        if (cnt_q == LastBit) begin
`ifdef SERIAL_DESER_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
`ifdef SERIAL_DESER_PARITY_EN
        par_d = par_q ^ din;
`endif
        state_d = StStop;
      end
      StStop: begin
        // The stop bit is never reused as a start bit, even when it is 1.
        state_d = StIdle;
        if (din) begin
          frame_err_d = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
        end else if (par_q) begin
          parity_err_d = 1'b1;
`endif
        end else begin
          commit = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
`ifdef SERIAL_DESER_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: vector table, corner-case sequences and a random frame stream
// checked against a frame-level reference model.
module tb_serial_deserializer;

  localparam int unsigned W = 8;
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overflow;
  logic         frame_err;
  logic         parity_err;

  int n_cmp = 0;
  int n_fail = 0;

  serial_deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         stop;
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_dout;
    logic         exp_ovf;
    logic         exp_ferr;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit, let one edge pass, sample 1ns later.
  task automatic tick(input logic d, input logic r);
    din        = d;
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Ends just after the edge that samples the stop bit.
  task automatic send_frame(input logic [W-1:0] data, input logic stop, input logic pflip,
                            input logic r, input logic r_stop);
    tick(1'b1, r);
    for (int i = 0; i < int'(W); i++) tick(data[i], r);
    if (ParEn) tick((^data) ^ pflip, r);
    tick(stop, r_stop);
  endtask

  // Random stream and its frame-level events, indexed by cycle.
  logic         s_bit[$];
  int           s_ev[$];    // 0 none, 1 good word, 2 frame error, 3 parity error
  logic [W-1:0] s_word[$];

  initial begin
    logic         early_valid;
    logic         any_flag;
    logic         exp_valid;
    logic [W-1:0] exp_dout;
    logic         exp_ovf;
    logic         r;
    logic [W-1:0] d;
    logic         bad_stop;
    logic         bad_par;
    int           gap;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[4] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[5] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};

    // Reset values.
    do_reset();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_flags", {29'h0, overflow, frame_err, parity_err}, 32'h0);

    // Latency of a single frame: valid appears right after the stop edge, for one cycle.
    early_valid = 1'b0;
    tick(1'b1, 1'b1);
    for (int k = 0; k < int'(W); k++) begin
      tick(logic'((8'hA5 >> k) & 8'h01), 1'b1);
      early_valid |= dout_valid;
    end
    if (ParEn) begin
      tick(^(8'hA5), 1'b1);
      early_valid |= dout_valid;
    end
    check("lat_no_early_valid", 32'(early_valid), 32'h0);
    tick(1'b0, 1'b1);
    check("lat_valid", 32'(dout_valid), 32'h1);
    check("lat_dout", 32'(dout), 32'hA5);
    tick(1'b0, 1'b1);
    check("lat_valid_one_cycle", 32'(dout_valid), 32'h0);

    // Vector table: each row is an idle cycle then a frame, ready held throughout.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, tbl[i].ready);
      check("tbl_gap_ovf", 32'(overflow), 32'h0);
      check("tbl_gap_ferr", 32'(frame_err), 32'h0);
      send_frame(tbl[i].data, tbl[i].stop, 1'b0, tbl[i].ready, tbl[i].ready);
      check("tbl_valid", 32'(dout_valid), 32'(tbl[i].exp_valid));
      check("tbl_dout", 32'(dout), 32'(tbl[i].exp_dout));
      check("tbl_ovf", 32'(overflow), 32'(tbl[i].exp_ovf));
      check("tbl_ferr", 32'(frame_err), 32'(tbl[i].exp_ferr));
      check("tbl_perr", 32'(parity_err), 32'h0);
    end

    // Back-to-back frames with the output never consumed.
    tick(1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_first_dout", 32'(dout), 32'h01);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_ovf", 32'(overflow), 32'h1);
    check("b2b_dout_kept", 32'(dout), 32'h01);
    check("b2b_valid_kept", 32'(dout_valid), 32'h1);
    tick(1'b0, 1'b0);
    check("b2b_ovf_one_cycle", 32'(overflow), 32'h0);

    // Full output consumed in the same cycle a new word commits.
    send_frame(8'h9C, 1'b0, 1'b0, 1'b0, 1'b1);
    check("same_cyc_dout", 32'(dout), 32'h9C);
    check("same_cyc_valid", 32'(dout_valid), 32'h1);
    check("same_cyc_ovf", 32'(overflow), 32'h0);

`ifdef SERIAL_DESER_PARITY_EN
    tick(1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
    check("par_bad_perr", 32'(parity_err), 32'h1);
    check("par_bad_valid", 32'(dout_valid), 32'h0);
    tick(1'b0, 1'b1);
    check("par_perr_one_cycle", 32'(parity_err), 32'h0);
    send_frame(8'h07, 1'b0, 1'b0, 1'b1, 1'b1);
    check("par_good_dout", 32'(dout), 32'h07);
    check("par_good_valid", 32'(dout_valid), 32'h1);
    check("par_good_perr", 32'(parity_err), 32'h0);
`endif

    // Reset in the middle of a frame, at data bit 4.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
    reset = 1'b1;
    tick(1'b1, 1'b0);
    reset = 1'b0;
    check("midrst_valid", 32'(dout_valid), 32'h0);
    check("midrst_dout", 32'(dout), 32'h0);
    any_flag = 1'b0;
    for (int k = 0; k < int'(W) + 4; k++) begin
      tick(1'b0, 1'b0);
      any_flag |= overflow | frame_err | parity_err | dout_valid;
    end
    check("midrst_quiet", 32'(any_flag), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    check("midrst_next_dout", 32'(dout), 32'h5A);
    check("midrst_next_valid", 32'(dout_valid), 32'h1);

    // Random frame stream against the frame-level model.
    for (int f = 0; f < 60; f++) begin
      gap      = int'($urandom_range(0, 2));
      d        = W'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
      bad_par  = ParEn && ($urandom_range(0, 5) == 0);
      for (int g = 0; g < gap; g++) begin
        s_bit.push_back(1'b0); s_ev.push_back(0); s_word.push_back('0);
      end
      s_bit.push_back(1'b1); s_ev.push_back(0); s_word.push_back('0);
      for (int i = 0; i < int'(W); i++) begin
        s_bit.push_back(d[i]); s_ev.push_back(0); s_word.push_back('0);
      end
      if (ParEn) begin
        s_bit.push_back((^d) ^ bad_par); s_ev.push_back(0); s_word.push_back('0);
      end
      s_bit.push_back(bad_stop);
      s_ev.push_back(bad_stop ? 2 : (bad_par ? 3 : 1));
      s_word.push_back(d);
    end
    for (int g = 0; g < 3; g++) begin
      s_bit.push_back(1'b0); s_ev.push_back(0); s_word.push_back('0);
    end

    do_reset();
    exp_valid = 1'b0;
    exp_dout  = '0;
    for (int i = 0; i < s_bit.size(); i++) begin
      r = logic'($urandom_range(0, 1));
      tick(s_bit[i], r);
      exp_ovf = 1'b0;
      if (s_ev[i] == 1) begin
        if (!exp_valid || r) begin
          exp_dout  = s_word[i];
          exp_valid = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
      end else if (exp_valid && r) begin
        exp_valid = 1'b0;
      end
      check("rnd_valid", 32'(dout_valid), 32'(exp_valid));
      check("rnd_dout", 32'(dout), 32'(exp_dout));
      check("rnd_ovf", 32'(overflow), 32'(exp_ovf));
      check("rnd_ferr", 32'(frame_err), 32'(s_ev[i] == 2));
      check("rnd_perr", 32'(parity_err), 32'(s_ev[i] == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
